// File: rtl/match_pkg.sv
// Shared types and 7-segment constants for the best-of-N match controller.
// Segment patterns are active-low in gfedcba order.
package match_pkg;

    typedef enum logic [1:0] {START, PLAY, HOLD, MATCH_OVER} state_t;
    typedef enum logic [1:0] {NONE, P1, P2} player_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        case (value)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational decimal-to-7-segment decoder with a blanking input.
// Values above 9 also show blank.
module seg7_digit
    import match_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : seg_encode(value);
    end

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer: resets the playfield between rounds, tallies round
// wins, freezes each result on screen and announces the match winner.
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       L,
    input  logic       R,
    input  logic       p1_round_win,
    input  logic       p2_round_win,
    output logic       round_reset,
    output logic       play_enable,
    output logic       match_over,
    output logic [6:0] score1_hex,
    output logic [6:0] score2_hex,
    output logic [6:0] winner_hex
);

    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [SW-1:0] WIN_VAL   = SW'(WIN_SCORE);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        state, state_next;
    player_t       winner, winner_next;
    logic [SW-1:0] score1, score1_next, score2, score2_next;
    logic [SW-1:0] inc1, inc2;
    logic [HW-1:0] hold_cnt, hold_next;

    // Saturating increments so a score can never wrap past WIN_SCORE.
    assign inc1 = (score1 == WIN_VAL) ? score1 : score1 + SW'(1);
    assign inc2 = (score2 == WIN_VAL) ? score2 : score2 + SW'(1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= START;
            winner   <= NONE;
            score1   <= '0;
            score2   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            winner   <= winner_next;
            score1   <= score1_next;
            score2   <= score2_next;
            hold_cnt <= hold_next;
        end
    end

    always_comb begin
        state_next  = state;
        winner_next = winner;
        score1_next = score1;
        score2_next = score2;
        hold_next   = hold_cnt;
        case (state)
            START: begin
                if (!L && !R) state_next = PLAY;
            end
            PLAY: begin
                if (p1_round_win && p2_round_win) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end else if (p1_round_win) begin
                    score1_next = inc1;
                    if (inc1 == WIN_VAL) begin
                        winner_next = P1;
                        state_next  = MATCH_OVER;
                    end else begin
                        state_next = HOLD;
                        hold_next  = '0;
                    end
                end else if (p2_round_win) begin
                    score2_next = inc2;
                    if (inc2 == WIN_VAL) begin
                        winner_next = P2;
                        state_next  = MATCH_OVER;
                    end else begin
                        state_next = HOLD;
                        hold_next  = '0;
                    end
                end
            end
            HOLD: begin
                // Win levels are ignored here, so a level still held does not score twice.
                if (hold_cnt == HOLD_LAST) state_next = START;
                else                       hold_next  = hold_cnt + HW'(1);
            end
            MATCH_OVER: begin
                if (L && R) begin
                    score1_next = '0;
                    score2_next = '0;
                    winner_next = NONE;
                    state_next  = START;
                end
            end
            default: state_next = START;
        endcase
    end

    assign round_reset = (state == START);
    assign play_enable = (state == PLAY);
    assign match_over  = (state == MATCH_OVER);

    seg7_digit u_score1 (
        .value (4'(score1)),
        .blank (1'b0),
        .seg   (score1_hex)
    );

    seg7_digit u_score2 (
        .value (4'(score2)),
        .blank (1'b0),
        .seg   (score2_hex)
    );

    seg7_digit u_winner (
        .value ((winner == P2) ? 4'd2 : 4'd1),
        .blank (winner == NONE),
        .seg   (winner_hex)
    );

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with WIN_SCORE=3 and HOLD_CYCLES=4;
// expected segment patterns are hand-written constants.
module tb_match_controller;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] BL = 7'b1111111;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       L, R, p1_round_win, p2_round_win;
    logic       round_reset, play_enable, match_over;
    logic [6:0] score1_hex, score2_hex, winner_hex;

    int vectors = 0;
    int miscompares = 0;

    match_controller #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .L            (L),
        .R            (R),
        .p1_round_win (p1_round_win),
        .p2_round_win (p2_round_win),
        .round_reset  (round_reset),
        .play_enable  (play_enable),
        .match_over   (match_over),
        .score1_hex   (score1_hex),
        .score2_hex   (score2_hex),
        .winner_hex   (winner_hex)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic checkCtl(input string tag, input logic rr, input logic pe, input logic mo);
        checkOutput({tag, ".round_reset"}, {6'd0, round_reset}, {6'd0, rr});
        checkOutput({tag, ".play_enable"}, {6'd0, play_enable}, {6'd0, pe});
        checkOutput({tag, ".match_over"},  {6'd0, match_over},  {6'd0, mo});
    endtask

    task automatic checkDigits(input string tag, input logic [6:0] s1, input logic [6:0] s2,
                               input logic [6:0] w);
        checkOutput({tag, ".score1_hex"}, score1_hex, s1);
        checkOutput({tag, ".score2_hex"}, score2_hex, s2);
        checkOutput({tag, ".winner_hex"}, winner_hex, w);
    endtask

    // From PLAY: one edge of the given win levels, then through HOLD and START back to PLAY.
    task automatic playRound(input logic w1, input logic w2);
        p1_round_win = w1;
        p2_round_win = w2;
        applyStimulus(1);
        p1_round_win = 1'b0;
        p2_round_win = 1'b0;
        applyStimulus(4);
        applyStimulus(1);
    endtask

    initial begin
        Reset = 1'b0;
        L = 1'b0; R = 1'b0;
        p1_round_win = 1'b0; p2_round_win = 1'b0;
        #3;
        checkCtl("reset", 1'b1, 1'b0, 1'b0);
        checkDigits("reset", D0, D0, BL);

        // Left button held through reset release keeps the controller in START.
        L = 1'b1;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkCtl("start_held", 1'b1, 1'b0, 1'b0);
        end
        L = 1'b0;
        applyStimulus(1);
        checkCtl("enter_play", 1'b0, 1'b1, 1'b0);

        // P1 win level stays high through HOLD; it must count once.
        p1_round_win = 1'b1;
        applyStimulus(1);
        checkCtl("hold0", 1'b0, 1'b0, 1'b0);
        checkDigits("p1_win", D1, D0, BL);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1);
            checkCtl("hold_n", 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1);
        checkCtl("hold_done", 1'b1, 1'b0, 1'b0);
        checkDigits("no_double", D1, D0, BL);
        p1_round_win = 1'b0;
        applyStimulus(1);
        checkCtl("replay", 1'b0, 1'b1, 1'b0);

        // Tie: both levels on the same edge leave scores unchanged.
        p1_round_win = 1'b1; p2_round_win = 1'b1;
        applyStimulus(1);
        p1_round_win = 1'b0; p2_round_win = 1'b0;
        checkCtl("tie_hold", 1'b0, 1'b0, 1'b0);
        checkDigits("tie", D1, D0, BL);
        applyStimulus(3);
        checkCtl("tie_hold_end", 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        checkCtl("tie_start", 1'b1, 1'b0, 1'b0);
        applyStimulus(1);
        checkCtl("tie_play", 1'b0, 1'b1, 1'b0);

        // Player 2 takes three rounds.
        playRound(1'b0, 1'b1);
        checkDigits("p2_r1", D1, D1, BL);
        checkCtl("p2_r1", 1'b0, 1'b1, 1'b0);
        playRound(1'b0, 1'b1);
        checkDigits("p2_r2", D1, D2, BL);
        p2_round_win = 1'b1;
        applyStimulus(1);
        p2_round_win = 1'b0;
        checkCtl("p2_match", 1'b0, 1'b0, 1'b1);
        checkDigits("p2_match", D1, D3, D2);

        // Win pulses and a single button are ignored once the match is over.
        p1_round_win = 1'b1;
        applyStimulus(1);
        p1_round_win = 1'b0;
        p2_round_win = 1'b1;
        applyStimulus(1);
        p2_round_win = 1'b0;
        L = 1'b1;
        applyStimulus(1);
        checkCtl("over_ignore", 1'b0, 1'b0, 1'b1);
        checkDigits("over_ignore", D1, D3, D2);

        // Both buttons clear the match; held buttons keep it in START.
        R = 1'b1;
        applyStimulus(1);
        checkCtl("clear", 1'b1, 1'b0, 1'b0);
        checkDigits("clear", D0, D0, BL);
        applyStimulus(1);
        checkCtl("clear_held", 1'b1, 1'b0, 1'b0);
        L = 1'b0; R = 1'b0;
        applyStimulus(1);
        checkCtl("clear_play", 1'b0, 1'b1, 1'b0);

        // Player 1 reaches two wins, then an asynchronous reset mid-PLAY.
        playRound(1'b1, 1'b0);
        playRound(1'b1, 1'b0);
        checkDigits("p1_two", D2, D0, BL);
        checkCtl("p1_two", 1'b0, 1'b1, 1'b0);
        #2 Reset = 1'b0;
        #1;
        checkCtl("async_reset", 1'b1, 1'b0, 1'b0);
        checkDigits("async_reset", D0, D0, BL);
        #2 Reset = 1'b1;
        applyStimulus(1);
        checkCtl("post_reset", 1'b0, 1'b1, 1'b0);

        // Player 1 sweeps the match to check the "1" winner digit.
        playRound(1'b1, 1'b0);
        playRound(1'b1, 1'b0);
        p1_round_win = 1'b1;
        applyStimulus(1);
        p1_round_win = 1'b0;
        checkCtl("p1_match", 1'b0, 1'b0, 1'b1);
        checkDigits("p1_match", D3, D0, D1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
